integer_reservation_station: RTL

INTEGER_RESERVATION_STATION -- requirements
Module: integer_reservation_station

---
 rtl/integer_reservation_station.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/integer_reservation_station.sv
// Integer reservation station: holds issued ops until both operands are
// available, snoops the CDB for missing operands and dispatches the
// lowest-index ready entry to a single integer lane.
module integer_reservation_station #(
    parameter int unsigned XLEN                = 64,
    parameter int unsigned ROB_INDEX_WIDTH     = 8,
    parameter int unsigned DECODED_INSTR_WIDTH = 6,
    parameter int unsigned RS_DEPTH            = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    // Issue side
    input  logic                           issue_valid,
    output logic                           issue_ready,
    input  logic [DECODED_INSTR_WIDTH-1:0] issue_decoded_instruction,
    input  logic [ROB_INDEX_WIDTH-1:0]     issue_ROB_index,
    input  logic [XLEN-1:0]                issue_PC,
    input  logic                           issue_1st_ready,
    input  logic [XLEN-1:0]                issue_1st_value,
    input  logic [ROB_INDEX_WIDTH-1:0]     issue_1st_tag,
    input  logic                           issue_2nd_ready,
    input  logic [XLEN-1:0]                issue_2nd_value,
    input  logic [ROB_INDEX_WIDTH-1:0]     issue_2nd_tag,
    // Result snoop
    input  logic                           cdb_valid,
    input  logic [ROB_INDEX_WIDTH-1:0]     cdb_ROB_index,
    input  logic [XLEN-1:0]                cdb_value,
    // Dispatch side
    output logic                           dispatch_valid,
    input  logic                           dispatch_ready,
    output logic [XLEN-1:0]                dispatch_1st_reg,
    output logic [XLEN-1:0]                dispatch_2nd_reg,
    output logic [DECODED_INSTR_WIDTH-1:0] dispatch_decoded_instruction,
    output logic [ROB_INDEX_WIDTH-1:0]     dispatch_ROB_index,
    output logic [XLEN-1:0]                dispatch_PC_i,
    // Squash
    input  logic                           flush
);

    localparam int unsigned IdxW = $clog2(RS_DEPTH);

    // Control state (reset) and payload (no reset needed)
    logic [RS_DEPTH-1:0] busy_q, busy_d;
    logic [RS_DEPTH-1:0] rdy1_q, rdy1_d, rdy2_q, rdy2_d;
    logic [DECODED_INSTR_WIDTH-1:0] op_q   [RS_DEPTH];
    logic [DECODED_INSTR_WIDTH-1:0] op_d   [RS_DEPTH];
    logic [ROB_INDEX_WIDTH-1:0]     rob_q  [RS_DEPTH];
    logic [ROB_INDEX_WIDTH-1:0]     rob_d  [RS_DEPTH];
    logic [XLEN-1:0]                pc_q   [RS_DEPTH];
    logic [XLEN-1:0]                pc_d   [RS_DEPTH];
    logic [XLEN-1:0]                val1_q [RS_DEPTH];
    logic [XLEN-1:0]                val1_d [RS_DEPTH];
    logic [XLEN-1:0]                val2_q [RS_DEPTH];
    logic [XLEN-1:0]                val2_d [RS_DEPTH];
    logic [ROB_INDEX_WIDTH-1:0]     tag1_q [RS_DEPTH];
    logic [ROB_INDEX_WIDTH-1:0]     tag1_d [RS_DEPTH];
    logic [ROB_INDEX_WIDTH-1:0]     tag2_q [RS_DEPTH];
    logic [ROB_INDEX_WIDTH-1:0]     tag2_d [RS_DEPTH];

    logic [RS_DEPTH-1:0] eligible;
    logic [IdxW-1:0]     free_idx, sel_idx;
    logic                any_eligible;
    logic                issue_fire, dispatch_fire;
    logic                in1_rdy, in2_rdy;

    // Eligibility uses registered state only, so a CDB wakeup shows up a cycle later
    assign eligible = busy_q & rdy1_q & rdy2_q;

    // Priority encoders: lowest free entry for issue, lowest eligible for dispatch
    always_comb begin
        free_idx     = '0;
        sel_idx      = '0;
        any_eligible = 1'b0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_idx = IdxW'(i);
            if (eligible[i]) begin
                sel_idx      = IdxW'(i);
                any_eligible = 1'b1;
            end
        end
    end

    assign issue_ready   = reset & ~(&busy_q);
    assign issue_fire    = issue_valid & issue_ready & ~flush;
    assign dispatch_fire = dispatch_valid & dispatch_ready;

    // Same-cycle CDB match at issue captures the broadcast value directly
    assign in1_rdy = issue_1st_ready | (cdb_valid & (cdb_ROB_index == issue_1st_tag));
    assign in2_rdy = issue_2nd_ready | (cdb_valid & (cdb_ROB_index == issue_2nd_tag));

    // Dispatch outputs: selected entry's registers, zeroed when nothing is eligible
    always_comb begin
        dispatch_valid               = any_eligible;
        dispatch_1st_reg             = '0;
        dispatch_2nd_reg             = '0;
        dispatch_decoded_instruction = '0;
        dispatch_ROB_index           = '0;
        dispatch_PC_i                = '0;
        if (any_eligible) begin
            dispatch_1st_reg             = val1_q[sel_idx];
            dispatch_2nd_reg             = val2_q[sel_idx];
            dispatch_decoded_instruction = op_q[sel_idx];
            dispatch_ROB_index           = rob_q[sel_idx];
            dispatch_PC_i                = pc_q[sel_idx];
        end
    end

    // Next state: wakeup, dispatch release, issue write; flush overrides busy
    always_comb begin
        busy_d = busy_q;
        rdy1_d = rdy1_q;
        rdy2_d = rdy2_q;
        op_d   = op_q;
        rob_d  = rob_q;
        pc_d   = pc_q;
        val1_d = val1_q;
        val2_d = val2_q;
        tag1_d = tag1_q;
        tag2_d = tag2_q;

        for (int i = 0; i < RS_DEPTH; i++) begin
            if (cdb_valid && busy_q[i]) begin
                if (!rdy1_q[i] && (tag1_q[i] == cdb_ROB_index)) begin
                    rdy1_d[i] = 1'b1;
                    val1_d[i] = cdb_value;
                end
                if (!rdy2_q[i] && (tag2_q[i] == cdb_ROB_index)) begin
                    rdy2_d[i] = 1'b1;
                    val2_d[i] = cdb_value;
                end
            end
        end

        if (dispatch_fire) busy_d[sel_idx] = 1'b0;

        // The free entry is never busy, so it cannot collide with wakeup or dispatch
        if (issue_fire) begin
            busy_d[free_idx] = 1'b1;
            op_d[free_idx]   = issue_decoded_instruction;
            rob_d[free_idx]  = issue_ROB_index;
            pc_d[free_idx]   = issue_PC;
            rdy1_d[free_idx] = in1_rdy;
            val1_d[free_idx] = issue_1st_ready ? issue_1st_value : cdb_value;
            tag1_d[free_idx] = issue_1st_tag;
            rdy2_d[free_idx] = in2_rdy;
            val2_d[free_idx] = issue_2nd_ready ? issue_2nd_value : cdb_value;
            tag2_d[free_idx] = issue_2nd_tag;
        end

        if (flush) busy_d = '0;
    end

    // Control state register with asynchronous clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
            rdy1_q <= '0;
            rdy2_q <= '0;
        end else begin
            busy_q <= busy_d;
            rdy1_q <= rdy1_d;
            rdy2_q <= rdy2_d;
        end
    end

    // Payload registers; only meaningful while the entry is busy
    always_ff @(posedge clock) begin
        op_q   <= op_d;
        rob_q  <= rob_d;
        pc_q   <= pc_d;
        val1_q <= val1_d;
        val2_q <= val2_d;
        tag1_q <= tag1_d;
        tag2_q <= tag2_d;
    end

endmodule
